muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. It sits beside the ALU and shares its `SrcA`/`SrcB` operands. Its registered `Result` feeds the execute-stage result mux, which chooses between `ALUResult` and `Result`. The controller asserts `start` for M-extension instructions and holds the pipeline while `busy` is high. The controller captures `Result` when `done` pulses.

## Interface
- `DATA_WIDTH`, 32, operand/result width (design verified at 32 only)
- `CNT_WIDTH`, 6, iteration counter width (must hold `DATA_WIDTH`)
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `SrcA`  in  DATA_WIDTH  rs1 operand (multiplicand / dividend)
- `SrcB`  in  DATA_WIDTH  rs2 operand (multiplier / divisor)
- `busy`  out  1  high in CALC and FIX
- `done`  out  1  one-cycle pulse, high only in DONE
- `Result`  out  DATA_WIDTH  registered result, held until next accepted start

## Operation
- States are IDLE, CALC, FIX and DONE.
- **IDLE**
  - On `start=1`: latch `funct3`, signs and magnitudes of the operands, and clear the counter.
  - Signed operands: A is signed for MUL/MULH/MULHSU/DIV/REM; B is signed for MUL/MULH/DIV/REM.
  - Unsigned operands are taken as-is.
  - Next state is CALC, or DONE for a special case (see below).
- **CALC, multiply**: one shift-add step per cycle on the 64-bit unsigned product of the magnitudes. 32 cycles.
- **CALC, divide**: one restoring shift-subtract step per cycle. Produces the unsigned quotient and remainder. 32 cycles.
- CALC exits to FIX when the counter reaches `DATA_WIDTH-1`.
- **FIX**: apply sign correction and select the output word, then register it into `Result`. Next state is DONE.
  - Product is negated if the product sign is 1. Product sign = signA^signB (MUL/MULH), signA (MULHSU), 0 (MULHU).
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
  - Quotient is negated if signA^signB (DIV). Remainder is negated if signA (REM).
- **DONE**: `done=1` for exactly one cycle, then IDLE unconditionally.
- Special cases, resolved in IDLE directly to DONE (no CALC/FIX):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `SrcA`.
  - Signed overflow (`SrcA`=0x80000000, `SrcB`=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- `start` in CALC, FIX or DONE is ignored. There is no queueing; the controller re-asserts `start` from IDLE.
- `funct3`/`SrcA`/`SrcB` changes after the accepting edge have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `Result`=0, counter 0, internal accumulators 0.
- Reset asserted mid-operation aborts on that edge. Same reset values apply; no `done` is produced.
- Let E0 be the edge that samples `start` in IDLE.
- **Normal ops**:
  - CALC covers edges E1..E32.
  - FIX is entered after E32; `Result` is registered at E33.
  - `done`=1 between E33 and E34.
  - `busy`=1 from after E0 to E33.
- **Special cases**: `Result` is registered at E0. `done`=1 between E0 and E1. `busy` never rises.
- `busy` and `done` are never high together.
- `Result` is valid from the `done` cycle onward and holds until the next accepted start's `Result` write.
- Back-to-back issue: the earliest next accept is the edge following the DONE cycle, i.e. IDLE after E34 (or after E1 for special cases).
- Outputs are purely registered; no combinational path from inputs to `busy`/`done`/`Result`.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `Result`=0xFFFFFFEB; `done` exactly 34 cycles after start edge counting E0 as 0 … check `done` high between E33–E34; `busy` high 33 cycles.
- MULH/MULHSU/MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF → 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; overflow DIV 0x80000000/−1 → 0x80000000, REM → 0. Each with `done` one cycle after start edge and `busy` never high.
- `start` held high through a whole MUL with changing operands → exactly one `done`; result matches operands sampled at E0; next op accepted only after returning to IDLE.
- `reset` pulsed at cycle 10 of a DIV → next cycle state IDLE, `busy`=0, `Result`=0, no `done`; a new start then completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [2:0]           op;
    logic                 sign_a;
    logic                 sign_b;
    logic [W-1:0]         mag_a;
    logic [W-1:0]         mag_b;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]       acc;

    logic         a_signed;
    logic         b_signed;
    logic         sa_in;
    logic         sb_in;
    logic [W-1:0] mag_a_in;
    logic [W-1:0] mag_b_in;
    logic         div_zero;
    logic         div_ovf;
    logic [W-1:0] special_res;

    assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign sa_in    = a_signed & SrcA[W-1];
    assign sb_in    = b_signed & SrcB[W-1];
    assign mag_a_in = sa_in ? -SrcA : SrcA;
    assign mag_b_in = sb_in ? -SrcB : SrcB;
    assign div_zero = funct3[2] && (SrcB == '0);
    assign div_ovf  = funct3[2] && !funct3[0]
                   && (SrcA == {1'b1, {(W-1){1'b0}}})
                   && (SrcB == '1);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? SrcA : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : SrcA;
    end

    // Multiply: multiplier sits in acc low half and shifts out as the sum shifts in.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_next = {mul_sum, acc[W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}.
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = div_diff[W]
                     ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                     : {div_diff[W-1:0], acc[W-2:0], 1'b1};

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fix_res;
    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
    assign rem_fix  = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_comb begin
        fix_res = '0;
        unique case (op)
            3'b000:                 fix_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            cnt    <= '0;
            acc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                        mag_a  <= mag_a_in;
                        mag_b  <= mag_b_in;
                        cnt    <= '0;
                        acc    <= funct3[2] ? {{W{1'b0}}, mag_a_in}
                                            : {{W{1'b0}}, mag_b_in};
                        if (div_zero || div_ovf) begin
                            Result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    if (cnt == CNT_WIDTH'(W - 1))
                        state <= FIX;
                    else
                        cnt <= cnt + 1'b1;
                end
                FIX: begin
                    Result <= fix_res;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: results, latency, special cases,
// held start and mid-operation reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    int first_done;
    int busy_cnt;
    int done_cnt;
    int ovl_cnt;

    muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next edge (E0) and observe n further edges.
    task automatic run(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit hold,
                       input int n);
        funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        @(posedge clk); #1;
        busy_cnt   = busy ? 1 : 0;
        done_cnt   = done ? 1 : 0;
        ovl_cnt    = (busy && done) ? 1 : 0;
        first_done = done ? 0 : -1;
        if (!hold) start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (hold) begin
                SrcA = $urandom;
                SrcB = $urandom;
            end
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (busy && done) ovl_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
        end
    endtask

    task automatic normal(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        run(f, a, b, 1'b0, 34);
        chk({tag, "_res"}, Result, exp);
        chk({tag, "_done_edge"}, first_done, 33);
    endtask

    task automatic special(input string tag, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        run(f, a, b, 1'b0, 2);
        chk({tag, "_res"}, Result, exp);
        chk({tag, "_done_edge"}, first_done, 0);
        chk({tag, "_busy_cnt"}, busy_cnt, 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", Result, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 34);
        chk("mul_res", Result, 32'hFFFF_FFEB);
        chk("mul_done_edge", first_done, 33);
        chk("mul_done_cnt", done_cnt, 1);
        chk("mul_busy_cnt", busy_cnt, 33);
        chk("mul_overlap", ovl_cnt, 0);

        normal("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        normal("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        normal("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        normal("div", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        normal("rem", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        normal("divu", 3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
        normal("remu", 3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001);
        normal("divu2", 3'b101, 32'd100, 32'd7, 32'd14);
        normal("remu2", 3'b111, 32'd100, 32'd7, 32'd2);

        special("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        special("remu0", 3'b111, 32'd5, 32'd0, 32'h0000_0005);
        special("ovf_div", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        special("ovf_rem", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // start held high; operands scrambled after E0
        run(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 34);
        chk("hold_res", Result, 32'hFFFF_FFEB);
        chk("hold_done_cnt", done_cnt, 1);
        chk("hold_done_edge", first_done, 33);
        chk("hold_idle_busy", busy, 0);
        @(posedge clk); #1;
        chk("hold_reaccept", busy, 1);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        run(3'b100, 32'd100, 32'd7, 1'b0, 9);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", Result, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        chk("abort_quiet", done_cnt, 0);

        normal("after_rst", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
